// File: rtl/memctrl_pkg.sv
// Shared types for the MEMCTRL host responder:
// FSM states, access types, BIST modes and default widths.
package memctrl_pkg;

    localparam int AW_DEF     = 16;
    localparam int DW_DEF     = 8;
    localparam int MSEL_W_DEF = 6;
    localparam int ECNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RD_WAIT = 2'd2
    } host_st_e;

    typedef enum logic [1:0] {
        ACC_NONE = 2'd0,
        ACC_WR   = 2'd1,
        ACC_RD   = 2'd2,
        ACC_ILL  = 2'd3
    } acc_e;

    typedef enum logic {
        BIST_OFF = 1'b0,
        BIST_ON  = 1'b1
    } bist_mode_e;

    // WEB/OEB are both active-low; both low is a bus conflict.
    function automatic acc_e acc_decode(input logic web, input logic oeb);
        acc_e a;
        unique case ({web, oeb})
            2'b01:   a = ACC_WR;
            2'b10:   a = ACC_RD;
            2'b00:   a = ACC_ILL;
            default: a = ACC_NONE;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/memctrl_host_rsp_if.sv
// Host strobe bus plus array request/response channel.
// slave = responder (DUT), master = host and array side.
interface memctrl_host_rsp_if #(
    parameter int AW     = 16,
    parameter int DW     = 8,
    parameter int MSEL_W = 6,
    parameter int ECNT_W = 8
);
    logic [AW-1:0]        ADDR;
    logic                 CE;
    logic                 CSB;
    logic                 WEB;
    logic                 OEB;
    logic [DW-1:0]        IDATA;
    logic [DW-1:0]        ODATA;
    logic                 BIST_EN;
    logic                 REQ_VALID;
    logic                 REQ_READY;
    logic                 REQ_WE;
    logic [MSEL_W-1:0]    REQ_MACRO;
    logic [AW-MSEL_W-1:0] REQ_WADDR;
    logic [DW-1:0]        REQ_WDATA;
    logic                 RSP_VALID;
    logic [DW-1:0]        RSP_DATA;
    logic                 HOST_BUSY;
    logic [ECNT_W-1:0]    ERR_CNT;

    modport slave (
        input  ADDR, CE, CSB, WEB, OEB, IDATA, BIST_EN,
        input  REQ_READY, RSP_VALID, RSP_DATA,
        output ODATA, REQ_VALID, REQ_WE, REQ_MACRO,
        output REQ_WADDR, REQ_WDATA, HOST_BUSY, ERR_CNT
    );

    modport master (
        output ADDR, CE, CSB, WEB, OEB, IDATA, BIST_EN,
        output REQ_READY, RSP_VALID, RSP_DATA,
        input  ODATA, REQ_VALID, REQ_WE, REQ_MACRO,
        input  REQ_WADDR, REQ_WDATA, HOST_BUSY, ERR_CNT
    );
endinterface

// File: rtl/memctrl_strobe_det.sv
// Strobe edge detector: one capture per rising edge of CE & ~CSB,
// classified by WEB/OEB into write, read or illegal.
module memctrl_strobe_det
    import memctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic ce,
    input  logic csb,
    input  logic web,
    input  logic oeb,
    output logic cap_wr,
    output logic cap_rd,
    output logic cap_ill
);
    logic sel;
    logic sel_q;
    logic cap;
    acc_e acc;

    assign sel = ce & ~csb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sel_q <= 1'b0;
        else     sel_q <= sel;
    end

    assign cap     = sel & ~sel_q;
    assign acc     = acc_decode(web, oeb);
    assign cap_wr  = cap & (acc == ACC_WR);
    assign cap_rd  = cap & (acc == ACC_RD);
    assign cap_ill = cap & (acc == ACC_ILL);

endmodule

// File: rtl/memctrl_host_rsp.sv
// MEMCTRL host responder: turns host strobes into array requests,
// returns read data on ODATA and counts dropped accesses.
module memctrl_host_rsp
    import memctrl_pkg::*;
#(
    parameter int AW     = AW_DEF,
    parameter int DW     = DW_DEF,
    parameter int MSEL_W = MSEL_W_DEF,
    parameter int ECNT_W = ECNT_W_DEF
) (
    input logic                CLK,
    input logic                RST,
    memctrl_host_rsp_if.slave  bus
);
    host_st_e             st_q;
    logic                 cap_wr;
    logic                 cap_rd;
    logic                 cap_ill;
    logic                 legal;
    logic                 bist;
    logic                 accept;
    logic                 err;
    logic                 hs;
    logic                 rd_done;
    logic                 we_q;
    logic [MSEL_W-1:0]    macro_q;
    logic [AW-MSEL_W-1:0] waddr_q;
    logic [DW-1:0]        wdata_q;
    logic [DW-1:0]        odata_q;
    logic [ECNT_W-1:0]    ecnt_q;

    memctrl_strobe_det u_det (
        .clk     (CLK),
        .rst     (RST),
        .ce      (bus.CE),
        .csb     (bus.CSB),
        .web     (bus.WEB),
        .oeb     (bus.OEB),
        .cap_wr  (cap_wr),
        .cap_rd  (cap_rd),
        .cap_ill (cap_ill)
    );

    assign bist   = (bist_mode_e'(bus.BIST_EN) == BIST_ON);
    assign legal  = cap_wr | cap_rd;
    assign accept = legal & ~bist & (st_q == IDLE);
    // Illegal, BIST-blocked and overrun all fold into one increment.
    assign err    = cap_ill | (legal & ~accept);
    assign hs     = (st_q == REQ) & bus.REQ_READY;
    assign rd_done = bus.RSP_VALID & ~we_q
                   & ((st_q == RD_WAIT) | hs);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            st_q <= IDLE;
        end else begin
            unique case (st_q)
                IDLE:    if (accept) st_q <= REQ;
                REQ: begin
                    if (hs) begin
                        if (we_q || rd_done) st_q <= IDLE;
                        else                 st_q <= RD_WAIT;
                    end
                end
                RD_WAIT: if (bus.RSP_VALID) st_q <= IDLE;
                default: st_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            we_q    <= 1'b0;
            macro_q <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= cap_wr;
            macro_q <= bus.ADDR[AW-1 -: MSEL_W];
            waddr_q <= bus.ADDR[AW-MSEL_W-1:0];
            wdata_q <= bus.IDATA;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)          odata_q <= '0;
        else if (rd_done) odata_q <= bus.RSP_DATA;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            ecnt_q <= '0;
        else if (err && (ecnt_q != {ECNT_W{1'b1}}))
            ecnt_q <= ecnt_q + ECNT_W'(1);
    end

    assign bus.REQ_VALID = (st_q == REQ);
    assign bus.HOST_BUSY = (st_q != IDLE);
    assign bus.REQ_WE    = we_q;
    assign bus.REQ_MACRO = macro_q;
    assign bus.REQ_WADDR = waddr_q;
    assign bus.REQ_WDATA = wdata_q;
    assign bus.ODATA     = odata_q;
    assign bus.ERR_CNT   = ecnt_q;

endmodule

// File: tb/tb_memctrl_host_rsp.sv
// Scoreboard bench for memctrl_host_rsp: expected requests are queued
// at strobe time and popped by a handshake monitor.
module tb_memctrl_host_rsp;
    import memctrl_pkg::*;

    typedef struct packed {
        logic       we;
        logic [5:0] macro;
        logic [9:0] waddr;
        logic [7:0] wdata;
    } req_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   hs_cnt = 0;
    int   exp_err = 0;
    req_t exp_q[$];

    memctrl_host_rsp_if bus ();

    memctrl_host_rsp u_dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    // Handshake monitor: sampled on the falling edge, ahead of the
    // rising edge that completes the transfer.
    always @(negedge CLK) begin
        req_t got, e;
        if (!RST && bus.REQ_VALID && bus.REQ_READY) begin
            got = {bus.REQ_WE, bus.REQ_MACRO, bus.REQ_WADDR, bus.REQ_WDATA};
            hs_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL req_unexpected: got %h, required none", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL req_fields: got %h, required %h", got, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic bump_err();
        if (exp_err < 255) exp_err++;
    endtask

    task automatic check_err(input string nm);
        checks++;
        if (bus.ERR_CNT !== 8'(exp_err)) begin
            errors++;
            $display("FAIL %s: ERR_CNT got %0d, required %0d",
                     nm, bus.ERR_CNT, exp_err);
        end
    endtask

    task automatic strobe(input logic [15:0] a, input logic [7:0] d,
                          input logic web, input logic oeb);
        bus.ADDR  = a;
        bus.IDATA = d;
        bus.WEB   = web;
        bus.OEB   = oeb;
        bus.CE    = 1'b1;
        bus.CSB   = 1'b0;
        tick();
        bus.CE  = 1'b0;
        bus.CSB = 1'b1;
        bus.WEB = 1'b1;
        bus.OEB = 1'b1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if ({bus.REQ_VALID, bus.REQ_WE, bus.HOST_BUSY} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctl: got %b, required 000",
                     {bus.REQ_VALID, bus.REQ_WE, bus.HOST_BUSY});
        end
        checks++;
        if ({bus.REQ_MACRO, bus.REQ_WADDR, bus.REQ_WDATA, bus.ODATA} !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got %h, required 0",
                     {bus.REQ_MACRO, bus.REQ_WADDR, bus.REQ_WDATA, bus.ODATA});
        end
        check_err("reset_err");
        RST = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        bus.REQ_READY = 1'b1;
        exp_q.push_back('{1'b1, 6'd61, 10'd600, 8'hA5});
        strobe(16'hF658, 8'hA5, 1'b0, 1'b1);
        checks++;
        if (bus.REQ_VALID !== 1'b1 || bus.HOST_BUSY !== 1'b1) begin
            errors++;
            $display("FAIL wr_valid: got %b%b, required 11",
                     bus.REQ_VALID, bus.HOST_BUSY);
        end
        tick();
        checks++;
        if (bus.HOST_BUSY !== 1'b0) begin
            errors++;
            $display("FAIL wr_done: HOST_BUSY got %b, required 0", bus.HOST_BUSY);
        end
        exp_q.push_back('{1'b0, 6'd61, 10'd600, 8'h11});
        strobe(16'hF658, 8'h11, 1'b1, 1'b0);
        bus.RSP_VALID = 1'b1;
        bus.RSP_DATA  = 8'hA5;
        tick();
        bus.RSP_VALID = 1'b0;
        checks++;
        if (bus.ODATA !== 8'hA5 || bus.HOST_BUSY !== 1'b0) begin
            errors++;
            $display("FAIL rd_data: got %h busy %b, required a5 busy 0",
                     bus.ODATA, bus.HOST_BUSY);
        end
    endtask

    task automatic test_backpressure();
        bus.REQ_READY = 1'b0;
        exp_q.push_back('{1'b0, 6'd0, 10'd0, 8'h00});
        strobe(16'h0000, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                bus.ADDR = 16'h1234; bus.IDATA = 8'h77;
                bus.WEB = 1'b0; bus.OEB = 1'b1;
                bus.CE = 1'b1; bus.CSB = 1'b0;
                bump_err();
            end
            if (i == 2) begin
                bus.CE = 1'b0; bus.CSB = 1'b1; bus.WEB = 1'b1;
            end
            checks++;
            if ({bus.REQ_VALID, bus.HOST_BUSY, bus.REQ_WE,
                 bus.REQ_MACRO, bus.REQ_WADDR} !== 19'h60000) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got %h, required 60000", i,
                         {bus.REQ_VALID, bus.HOST_BUSY, bus.REQ_WE,
                          bus.REQ_MACRO, bus.REQ_WADDR});
            end
            tick();
        end
        check_err("bp_overrun");
        bus.REQ_READY = 1'b1;
        bus.RSP_VALID = 1'b1;
        bus.RSP_DATA  = 8'h3C;
        tick();
        bus.RSP_DATA = 8'h77;
        tick();
        bus.RSP_VALID = 1'b0;
        checks++;
        if (bus.ODATA !== 8'h3C || bus.HOST_BUSY !== 1'b0) begin
            errors++;
            $display("FAIL bp_data: got %h busy %b, required 3c busy 0",
                     bus.ODATA, bus.HOST_BUSY);
        end
    endtask

    task automatic test_illegal_noop();
        strobe(16'h4321, 8'h00, 1'b0, 1'b0);
        bump_err();
        tick();
        check_err("illegal");
        strobe(16'h4321, 8'h00, 1'b1, 1'b1);
        tick();
        check_err("noop");
        checks++;
        if (bus.HOST_BUSY !== 1'b0) begin
            errors++;
            $display("FAIL noop_busy: got %b, required 0", bus.HOST_BUSY);
        end
    endtask

    task automatic test_bist();
        bus.BIST_EN = 1'b1;
        strobe(16'hECC8, 8'h5A, 1'b0, 1'b1);
        bump_err();
        checks++;
        if (bus.HOST_BUSY !== 1'b0) begin
            errors++;
            $display("FAIL bist_busy: got %b, required 0", bus.HOST_BUSY);
        end
        tick();
        check_err("bist_block");
        bus.BIST_EN = 1'b0;
        exp_q.push_back('{1'b1, 6'd59, 10'd200, 8'h5A});
        strobe(16'hECC8, 8'h5A, 1'b0, 1'b1);
        tick();
        check_err("bist_off");
    endtask

    task automatic test_long_strobe();
        int hs0;
        hs0 = hs_cnt;
        exp_q.push_back('{1'b1, 6'd1, 10'd2, 8'hC3});
        bus.ADDR = 16'h0402; bus.IDATA = 8'hC3;
        bus.WEB = 1'b0; bus.OEB = 1'b1;
        bus.CE = 1'b1; bus.CSB = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        bus.CE = 1'b0; bus.CSB = 1'b1; bus.WEB = 1'b1;
        tick();
        tick();
        checks++;
        if (hs_cnt - hs0 != 1) begin
            errors++;
            $display("FAIL long_strobe: requests got %0d, required 1", hs_cnt - hs0);
        end
        check_err("long_strobe_err");
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 300; i++) begin
            strobe(16'h0000, 8'h00, 1'b0, 1'b0);
            bump_err();
            tick();
        end
        check_err("saturate");
        checks++;
        if (bus.ERR_CNT !== 8'hFF) begin
            errors++;
            $display("FAIL saturate_ff: got %h, required ff", bus.ERR_CNT);
        end
    endtask

    task automatic test_reset_mid_read();
        exp_q.push_back('{1'b0, 6'd2, 10'd3, 8'h00});
        strobe(16'h0803, 8'h00, 1'b1, 1'b0);
        tick();
        checks++;
        if (bus.HOST_BUSY !== 1'b1 || bus.REQ_VALID !== 1'b0) begin
            errors++;
            $display("FAIL rdwait: got busy %b valid %b, required 1 0",
                     bus.HOST_BUSY, bus.REQ_VALID);
        end
        #2;
        RST = 1'b1;
        exp_err = 0;
        #1;
        checks++;
        if ({bus.REQ_VALID, bus.HOST_BUSY, bus.ODATA} !== 10'h0) begin
            errors++;
            $display("FAIL rst_async: got %h, required 0",
                     {bus.REQ_VALID, bus.HOST_BUSY, bus.ODATA});
        end
        check_err("rst_err");
        tick();
        RST = 1'b0;
        tick();
        bus.RSP_VALID = 1'b1;
        bus.RSP_DATA  = 8'h99;
        tick();
        bus.RSP_VALID = 1'b0;
        checks++;
        if (bus.ODATA !== 8'h00 || bus.HOST_BUSY !== 1'b0) begin
            errors++;
            $display("FAIL late_rsp: got %h busy %b, required 00 busy 0",
                     bus.ODATA, bus.HOST_BUSY);
        end
    endtask

    initial begin
        bus.ADDR = '0; bus.IDATA = '0;
        bus.CE = 1'b0; bus.CSB = 1'b1;
        bus.WEB = 1'b1; bus.OEB = 1'b1;
        bus.BIST_EN = 1'b0; bus.REQ_READY = 1'b0;
        bus.RSP_VALID = 1'b0; bus.RSP_DATA = '0;
        test_reset();
        test_write_read();
        test_backpressure();
        test_illegal_noop();
        test_bist();
        test_long_strobe();
        test_saturation();
        test_reset_mid_read();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL req_missing: %0d pending, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
